// File: rtl/pipelined_addsub_if.sv
// Handshake/operand bundle for pipelined_addsub.
//   slave  : the adder side (consumes operands, produces results)
//   master : the source/consumer side that drives operands and out_ready
// Signals:
//   in_valid/in_ready : operand beat handshake
//   a, b              : WIDTH-bit unsigned operands
//   cin               : carry-in (add) or borrow-in (sub)
//   op                : 0 = add, 1 = subtract
//   out_valid/out_ready : result beat handshake
//   out               : WIDTH+1-bit result, MSB is carry (add) or borrow (sub)
// WIDTH must match the WIDTH of the pipelined_addsub instance it is bound to.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, out
  );

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: generic-width adder/subtractor with carry-in whose carry
// chain is cut into STAGES registered segments of SEG = WIDTH/STAGES bits.
// Valid/ready on both sides; a single global enable stalls the whole pipe
// under backpressure, so in_ready is purely combinational.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        pipelined_addsub_if.slave (in_valid/in_ready, a, b, cin, op,
//              out_valid/out_ready, out[WIDTH:0])
//   txn_count  [31:0] output-transfer counter, present only when the macro
//              ADDER_TXN_CNT_EN is defined (wraps, holds during stalls)
//
// Parameters:
//   WIDTH   operand width, multiple of STAGES
//   STAGES  pipeline depth / number of carry segments (1..WIDTH)
//
// Latency is STAGES cycles from input transfer to out_valid without stalls.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_addsub_if.slave    bus
`ifdef ADDER_TXN_CNT_EN
  ,
  output logic [31:0]          txn_count
`endif
);

  // Guarded so an illegal STAGES=0 reaches the elaboration error below
  // instead of a divide-by-zero here.
  localparam int unsigned SEG  = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
  localparam int unsigned LAST = (STAGES == 0) ? 0 : STAGES - 1;

  if ((STAGES < 1) || ((WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0)) begin : g_param_check
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
           WIDTH, STAGES);
  end

  logic en;

  // Per-stage inputs: stage 0 takes the bus, stage k takes register k-1.
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_bx  [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_c   [STAGES];
  logic             src_op  [STAGES];
  logic             src_v   [STAGES];
  logic [SEG:0]     seg_res [STAGES];

  // Stage registers. a/bx travel alongside so later stages see their slices;
  // sum accumulates the already-resolved low slices.
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bx_d    [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_d [STAGES];
  logic             carry_q [STAGES];
  logic             op_d    [STAGES];
  logic             op_q    [STAGES];
  logic             valid_d [STAGES];
  logic             valid_q [STAGES];

  // Global enable: the pipe advances whenever the output slot is empty or
  // being drained this cycle.
  always_comb begin
    en            = !valid_q[LAST] || bus.out_ready;
    bus.in_ready  = en;
    bus.out_valid = valid_q[LAST];
    // Subtraction is a + ~b + !cin, so the final carry is the inverse of borrow.
    bus.out       = {(op_q[LAST] ? ~carry_q[LAST] : carry_q[LAST]), sum_q[LAST]};
  end

  always_comb begin
    src_a[0]   = bus.a;
    src_bx[0]  = bus.op ? ~bus.b : bus.b;
    src_c[0]   = bus.op ? ~bus.cin : bus.cin;
    src_op[0]  = bus.op;
    src_v[0]   = bus.in_valid;
    src_sum[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_bx[k]  = bx_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_op[k]  = op_q[k-1];
      src_v[k]   = valid_q[k-1];
      src_sum[k] = sum_q[k-1];
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_res[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                 + {1'b0, src_bx[k][k*SEG +: SEG]}
                 + (SEG+1)'(src_c[k]);
      a_d[k]     = src_a[k];
      bx_d[k]    = src_bx[k];
      sum_d[k]   = src_sum[k];
      sum_d[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      carry_d[k] = seg_res[k][SEG];
      op_d[k]    = src_op[k];
      valid_d[k] = src_v[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        bx_q[k]    <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        op_q[k]    <= 1'b0;
        valid_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]     <= a_d[k];
        bx_q[k]    <= bx_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        op_q[k]    <= op_d[k];
        valid_q[k] <= valid_d[k];
      end
    end
  end

`ifdef ADDER_TXN_CNT_EN
  logic [31:0] txn_count_d;
  logic [31:0] txn_count_q;

  always_comb begin
    txn_count_d = txn_count_q;
    if (bus.out_valid && bus.out_ready) begin
      txn_count_d = txn_count_q + 32'd1;
    end
    txn_count = txn_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vectors on WIDTH=8/
// STAGES=2 and WIDTH=8/STAGES=1, plus a random-handshake run on
// WIDTH=32/STAGES=4 against a reference adder model.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_addsub_if #(.WIDTH(8))  if0 ();
  pipelined_addsub_if #(.WIDTH(32)) if1 ();
  pipelined_addsub_if #(.WIDTH(8))  if2 ();

`ifdef ADDER_TXN_CNT_EN
  logic [31:0] txn0, txn1, txn2;
`endif

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
`ifdef ADDER_TXN_CNT_EN
    , .txn_count(txn0)
`endif
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef ADDER_TXN_CNT_EN
    , .txn_count(txn1)
`endif
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
`ifdef ADDER_TXN_CNT_EN
    , .txn_count(txn2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic op);
    if0.in_valid = 1'b1;
    if0.a        = a;
    if0.b        = b;
    if0.cin      = cin;
    if0.op       = op;
  endtask

  // One isolated beat on dut0: accepted, invisible after 1 cycle, visible after 2.
  task automatic beat0(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic op, input logic [8:0] exp);
    @(negedge clk);
    drive0(a, b, cin, op);
    #1 check({tag, " in_ready"}, 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 check({tag, " valid@1"}, 64'(if0.out_valid), 64'd0);
    @(negedge clk);
    #1 check({tag, " valid@2"}, 64'(if0.out_valid), 64'd1);
    check({tag, " out"}, 64'(if0.out), 64'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [8:0] exp_bp [4] = '{9'h003, 9'h1F0, 9'h100, 9'h1FF};
  logic [7:0] a_bp   [4] = '{8'h01, 8'h10, 8'hAA, 8'h00};
  logic [7:0] b_bp   [4] = '{8'h02, 8'h20, 8'h55, 8'h00};
  logic       c_bp   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       o_bp   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [32:0] q [$];

  initial begin
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.op = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.op = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.op = 1'b0; if2.out_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("rst out_valid", 64'(if0.out_valid), 64'd0);
    check("rst out", 64'(if0.out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-rst in_ready", 64'(if0.in_ready), 64'd1);

    // Single beats: carry across segment boundary, borrow, carry-in edge cases
    beat0("add_carry",  8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
    beat0("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 9'h1FE);
    beat0("sub_nobrw",  8'h07, 8'h05, 1'b1, 1'b1, 9'h001);
    beat0("add_cin",    8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
    beat0("sub_0_ff",   8'h00, 8'hFF, 1'b0, 1'b1, 9'h101);

    // Back-to-back mixed ops
    @(negedge clk);
    drive0(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive0(8'h80, 8'h01, 1'b0, 1'b1);
    #1 check("b2b valid@1", 64'(if0.out_valid), 64'd0);
    @(negedge clk);
    drive0(8'hFF, 8'hFF, 1'b1, 1'b0);
    #1 check("b2b r0", 64'(if0.out), 64'h030);
    check("b2b v0", 64'(if0.out_valid), 64'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 check("b2b r1", 64'(if0.out), 64'h07F);
    check("b2b v1", 64'(if0.out_valid), 64'd1);
    @(negedge clk);
    #1 check("b2b r2", 64'(if0.out), 64'h1FF);
    check("b2b v2", 64'(if0.out_valid), 64'd1);
    @(negedge clk);
    #1 check("b2b drained", 64'(if0.out_valid), 64'd0);

    // Backpressure: out_ready low for cycles 3..7 with beats in flight
    pulse_reset();
    begin
      int sent = 0;
      int got  = 0;
      logic [8:0] held = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        if0.out_ready = !(cyc >= 3 && cyc < 8);
        if (sent < 4) drive0(a_bp[sent], b_bp[sent], c_bp[sent], o_bp[sent]);
        else          if0.in_valid = 1'b0;
        #1;
        if (cyc >= 3 && cyc < 8) begin
          check("bp stall valid", 64'(if0.out_valid), 64'd1);
          check("bp stall in_ready", 64'(if0.in_ready), 64'd0);
          if (cyc > 3) check("bp hold", 64'(if0.out), 64'(held));
          held = if0.out;
        end
        if (if0.out_valid && if0.out_ready) begin
          check("bp result", 64'(if0.out), 64'(exp_bp[got]));
          got++;
        end
        if (if0.in_valid && if0.in_ready) sent++;
      end
      if0.in_valid  = 1'b0;
      if0.out_ready = 1'b1;
      check("bp delivered", 64'(got), 64'd4);
      @(negedge clk);
      #1 check("bp no dup", 64'(if0.out_valid), 64'd0);
`ifdef ADDER_TXN_CNT_EN
      check("bp txn_count", 64'(txn0), 64'd4);
`endif
    end

    // Reset mid-operation
    @(negedge clk);
    drive0(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    drive0(8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 check("midrst pre valid", 64'(if0.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1 check("midrst async drop", 64'(if0.out_valid), 64'd0);
    check("midrst out", 64'(if0.out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("midrst no stale", 64'(if0.out_valid), 64'd0);
    end
    beat0("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 9'h002);

    // STAGES=1: single registered adder
    @(negedge clk);
    if2.in_valid = 1'b1; if2.a = 8'hFF; if2.b = 8'h01; if2.cin = 1'b0; if2.op = 1'b0;
    @(negedge clk);
    if2.a = 8'h05; if2.b = 8'h07; if2.cin = 1'b0; if2.op = 1'b1;
    #1 check("s1 v0", 64'(if2.out_valid), 64'd1);
    check("s1 r0", 64'(if2.out), 64'h100);
    @(negedge clk);
    if2.in_valid = 1'b0;
    #1 check("s1 r1", 64'(if2.out), 64'h1FE);
    @(negedge clk);
    #1 check("s1 drained", 64'(if2.out_valid), 64'd0);

    // WIDTH=32/STAGES=4 with random valid/ready against a reference model
    begin
      int sent = 0;
      int rcv  = 0;
      logic [31:0] ra, rb;
      logic rc, ro;
      logic [32:0] model, exp;
      for (int cyc = 0; cyc < 4000 && rcv < 300; cyc++) begin
        @(negedge clk);
        if1.out_ready = ($urandom_range(0, 3) != 0);
        if (sent < 300 && $urandom_range(0, 3) != 0) begin
          ra = $urandom;
          rb = $urandom;
          if ($urandom_range(0, 7) == 0) ra = '1;
          rc = 1'($urandom_range(0, 1));
          ro = 1'($urandom_range(0, 1));
          if1.in_valid = 1'b1; if1.a = ra; if1.b = rb; if1.cin = rc; if1.op = ro;
        end else begin
          if1.in_valid = 1'b0;
        end
        #1;
        if (if1.out_valid && if1.out_ready) begin
          exp = (q.size() > 0) ? q.pop_front() : 'x;
          check("rnd result", 64'(if1.out), 64'(exp));
          rcv++;
        end
        if (if1.in_valid && if1.in_ready) begin
          model = ro ? ({1'b0, ra} - {1'b0, rb} - 33'(rc))
                     : ({1'b0, ra} + {1'b0, rb} + 33'(rc));
          q.push_back(model);
          sent++;
        end
      end
      if1.in_valid = 1'b0;
      check("rnd received", 64'(rcv), 64'd300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
